cbus_axi_bridge: RTL and testbench
==================================

Name: cbus_axi_bridge

Overview:
- Sits directly downstream of the top-level CPU wrapper.
- Consumes the single arbitrated, address-translated CBus request (oreq/oresp) and converts it into one AXI4 master transaction on the SoC memory bus.
- Handles one outstanding transaction at a time.
- Write completion is reported to CBus only after the AXI B response, so uncached/MMIO stores are strictly ordered.

Parameters:
- AXI_ID_WIDTH, 4, width of arid/awid.
- AXI_ID, 0, constant ID driven on arid/awid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- creq  in  cbus_req_t  CBus request from the CPU wrapper: valid, is_write, size[2:0], addr[31:0], strobe[3:0], data[31:0], len[3:0] (beats-1)
- cresp  out  cbus_resp_t  CBus response: ready, last, data[31:0]
- axi_req  out  axi_req_t  AR/AW/W channel payloads + valids, rready, bready
- axi_resp  in  axi_resp_t  arready, awready, wready, rvalid/rdata/rlast/rresp, bvalid/bresp

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: all AXI valids, rready, bready = 0; cresp = '0; state = IDLE; beat counter = 0.
- Reset mid-operation: same values next edge. The in-flight AXI transaction is abandoned (system-wide reset).
- States: IDLE, AR, R, AW, W, B.
- IDLE:
  - creq.valid && !is_write -> latch addr/size/len; go to AR.
  - creq.valid && is_write -> latch; go to AW.
  - cresp = 0.
- AR:
  - arvalid = 1; araddr/arlen/arsize come from latched registers, stable until handshake.
  - arburst = INCR; arid = AXI_ID.
  - arvalid first rises the cycle after creq.valid is sampled in IDLE (1-cycle request latency).
  - arvalid && arready -> R.
- R:
  - rready = 1.
  - cresp.ready = rvalid; cresp.data = rdata; cresp.last = rvalid && rlast (combinational pass-through, zero added latency).
  - rvalid && rlast -> IDLE.
- AW:
  - awvalid = 1, same field rules as AR.
  - awvalid && awready -> W; beat counter cleared to 0.
- W:
  - wvalid = 1; wdata = creq.data; wstrb = creq.strobe.
  - wlast = (beat counter == latched len).
  - On a non-final wvalid && wready: cresp.ready = 1, cresp.last = 0, counter += 1.
  - On the final beat handshake: cresp.ready stays 0 (master keeps holding its last beat); go to B.
- B:
  - bready = 1.
  - On bvalid: cresp.ready = 1, cresp.last = 1; go to IDLE.
- len = 0 (single beat):
  - Read: one R beat carrying rlast.
  - Write: no W-phase cresp.ready; the single cresp.ready/last pulse comes in B.
- len = 15: counter is 4 bits and never wraps during a burst; wlast asserts at counter == 15.
- rresp/bresp are ignored (CBus has no error path). rlast arriving before len+1 beats still terminates the transaction.
- The master deasserts creq.valid in the cycle after cresp.last. The request seen in IDLE that cycle is therefore a new request.
- Back-to-back: IDLE is spent for at least one cycle between transactions.
- aw and w are never concurrently valid; ar and aw are never concurrently valid.

Decomposition:
- Package axi_pkg holds:
  - axi_req_t, axi_resp_t
  - AXI_BURST_INCR = 2'b01
  - the bridge state enum
- cbus_req_t/cbus_resp_t stay in the existing bus package.
- No sub-module: FSM, latched request and beat counter live in one module.

Test Plan:
- Single read, addr 0x1FC00000, size 2, len 0; arready delayed 3 cycles:
  - araddr = 0x1FC00000, arlen = 0, arsize = 2, held stable 4 cycles.
  - rdata 0xDEADBEEF with rlast -> cresp.ready = last = 1, data = 0xDEADBEEF in the same cycle.
- Burst read, len 3, addr 0x00001000:
  - 4 R beats with an rvalid gap after beat 1 -> exactly 4 cresp.ready pulses.
  - last only on the 4th; arlen = 3, arburst = 01.
- Single write, addr 0xBFAF8000, strobe 4'b0011, data 0x12345678, len 0; bvalid 5 cycles after wlast:
  - wstrb = 0011, wlast = 1.
  - cresp.ready/last pulse only in the bvalid cycle.
- Burst write, len 15, wready toggling every cycle:
  - 15 non-last cresp.ready pulses, wlast on the 16th beat, then one last pulse on bvalid.
  - awvalid never overlaps wvalid.
- reset asserted during beat 2 of a len-3 read:
  - All valids/readies = 0 at the next edge; state IDLE.
  - A subsequent read completes normally.
- Write (len 0) followed immediately by a read request:
  - arvalid rises no earlier than 2 cycles after the write's cresp.last.
  - No AR during AW/W/B.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI4 master-side channel bundles and the CBus-to-AXI bridge state encoding.
package axi_pkg;

  localparam int         AXI_ID_W       = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [AXI_ID_W-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic [AXI_ID_W-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                rready;
    logic                bready;
  } axi_req_t;

  typedef struct packed {
    logic        arready;
    logic        awready;
    logic        wready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;
    logic        bvalid;
    logic [1:0]  bresp;
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } bridge_state_e;

  // CBus carries a 4-bit beats-1 count; AXI4 burst length is 8 bits wide.
  function automatic logic [7:0] to_axi_len(input logic [3:0] len);
    return {4'b0000, len};
  endfunction

endpackage

// File: rtl/cbus_pkg.sv
// CBus request/response payloads shared by the CPU wrapper and its downstream bus agents.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;     // beats - 1
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_axi_bridge.sv
// Converts one CBus request at a time into a single AXI4 read or write burst.
// Write completion is returned to CBus only after the B response so that
// uncached/MMIO stores stay strictly ordered.
module cbus_axi_bridge
  import cbus_pkg::*;
  import axi_pkg::*;
#(
  parameter int                      AXI_ID_WIDTH = 4,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID       = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output axi_req_t   axi_req,
  input  axi_resp_t  axi_resp
);

  bridge_state_e state;
  logic [31:0]   addr_q;
  logic [2:0]    size_q;
  logic [3:0]    len_q;
  logic [3:0]    beat_q;
  logic          arvalid_q;
  logic          awvalid_q;
  logic          wvalid_q;
  logic          rready_q;
  logic          bready_q;
  logic          final_beat;

  assign final_beat = (beat_q == len_q);

  // CBus has no error path, so the AXI response codes are deliberately dropped.
  logic unused_resp;
  assign unused_resp = ^{axi_resp.rresp, axi_resp.bresp};

  // Transaction FSM: latches the request and owns every AXI valid/ready flag.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (creq.valid) begin
            addr_q <= creq.addr;
            size_q <= creq.size;
            len_q  <= creq.len;
            if (creq.is_write) begin
              awvalid_q <= 1'b1;
              state     <= ST_AW;
            end else begin
              arvalid_q <= 1'b1;
              state     <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (axi_resp.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_R;
          end
        end
        ST_R: begin
          // rlast ends the read even if fewer than len+1 beats arrived.
          if (axi_resp.rvalid && axi_resp.rlast) begin
            rready_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (axi_resp.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= '0;
            state     <= ST_W;
          end
        end
        ST_W: begin
          if (axi_resp.wready) begin
            if (final_beat) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state    <= ST_B;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        ST_B: begin
          if (axi_resp.bvalid) begin
            bready_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // AXI channel payloads: address fields from the latched request, write data live from CBus.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    axi_req         = '0;
    axi_req.arid    = AXI_ID_W'(AXI_ID);
    axi_req.araddr  = addr_q;
    axi_req.arlen   = to_axi_len(len_q);
    axi_req.arsize  = size_q;
    axi_req.arburst = AXI_BURST_INCR;
    axi_req.arvalid = arvalid_q;
    axi_req.awid    = AXI_ID_W'(AXI_ID);
    axi_req.awaddr  = addr_q;
    axi_req.awlen   = to_axi_len(len_q);
    axi_req.awsize  = size_q;
    axi_req.awburst = AXI_BURST_INCR;
    axi_req.awvalid = awvalid_q;
    axi_req.wdata   = creq.data;
    axi_req.wstrb   = creq.strobe;
    axi_req.wlast   = wvalid_q && final_beat;
    axi_req.wvalid  = wvalid_q;
    axi_req.rready  = rready_q;
    axi_req.bready  = bready_q;
  end

  // CBus response: zero-latency pass-through of R beats, W acceptance and B completion.
  always_comb begin
    cresp = '0;
    unique case (state)
      ST_R: begin
        cresp.ready = axi_resp.rvalid;
        cresp.last  = axi_resp.rvalid && axi_resp.rlast;
        cresp.data  = axi_resp.rdata;
      end
      // The final write beat is acknowledged only once B arrives.
      ST_W: cresp.ready = axi_resp.wready && !final_beat;
      ST_B: begin
        cresp.ready = axi_resp.bvalid;
        cresp.last  = axi_resp.bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Randomized bench for cbus_axi_bridge: the bench plays both the CBus master
// and the AXI slave, and checks the bridge against a transaction-level model.
`timescale 1ns/1ps
module tb_cbus_axi_bridge;
  import cbus_pkg::*;
  import axi_pkg::*;

  localparam logic [3:0] TB_ID = 4'h5;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  axi_req_t   axi_req;
  axi_resp_t  axi_resp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cbus_axi_bridge #(.AXI_ID_WIDTH(4), .AXI_ID(TB_ID)) dut (
    .clk      (clk),
    .reset    (reset),
    .creq     (creq),
    .cresp    (cresp),
    .axi_req  (axi_req),
    .axi_resp (axi_resp)
  );

  // Channel-exclusivity monitor: AR never alongside AW/W/B, AW never alongside W.
  int ovl_cnt = 0;
  always @(negedge clk) begin
    if ((axi_req.arvalid && (axi_req.awvalid || axi_req.wvalid || axi_req.bready)) ||
        (axi_req.awvalid && axi_req.wvalid))
      ovl_cnt <= ovl_cnt + 1;
  end

  // Model data and observations of the current transaction.
  logic [31:0] exp_q[$];
  logic [31:0] obs_data[$];
  logic        obs_last[$];
  logic [31:0] obs_wdata[$];
  logic [3:0]  obs_wstrb[$];
  logic        obs_wlast[$];
  int          addr_rise, addr_cycles, pulse_cnt, last_cnt, last_in_b, stray, timeout;
  bit          a_stable;
  logic [48:0] a_fields;
  logic [4:0]  post_v;
  cbus_resp_t  post_c;

  function automatic void obs_reset();
    exp_q.delete(); obs_data.delete(); obs_last.delete();
    obs_wdata.delete(); obs_wstrb.delete(); obs_wlast.delete();
    addr_rise = -1; addr_cycles = 0; pulse_cnt = 0; last_cnt = 0;
    last_in_b = 0; stray = 0; timeout = 0; a_stable = 1'b1; a_fields = '0;
  endfunction

  function automatic void cap_addr(input logic [48:0] f, input int cyc);
    if (addr_cycles == 0) begin
      addr_rise = cyc;
      a_fields  = f;
    end else if (f !== a_fields) begin
      a_stable = 1'b0;
    end
    addr_cycles++;
  endfunction

  function automatic int read_data_errs();
    int e = 0;
    if (obs_data.size() != exp_q.size()) return 100;
    foreach (exp_q[i]) begin
      if (obs_data[i] !== exp_q[i]) e++;
      if (obs_last[i] !== (i == exp_q.size() - 1)) e++;
    end
    return e;
  endfunction

  function automatic int write_beat_errs(input logic [3:0] strobe);
    int e = 0;
    if (obs_wdata.size() != exp_q.size()) return 100;
    foreach (exp_q[i]) begin
      if (obs_wdata[i] !== exp_q[i]) e++;
      if (obs_wstrb[i] !== strobe) e++;
      if (obs_wlast[i] !== (i == exp_q.size() - 1)) e++;
    end
    return e;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      creq = '0; axi_resp = '0;
    end
  endtask

  // Read: bench is master and AXI slave. last_at < len models an early rlast;
  // rst_at >= 0 asserts reset together with that beat.
  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] len,
                         input int ar_delay, input int gap_after, input int last_at, input int rst_at);
    int  beat = 0;
    bit  gap_done = 1'b0;
    bit  done = 1'b0;
    obs_reset();
    for (int i = 0; i <= last_at; i++) exp_q.push_back($urandom);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      axi_resp = '0;
      creq.valid = 1'b1; creq.is_write = 1'b0; creq.data = $urandom; creq.strobe = 4'($urandom);
      if (cyc == 0) begin
        creq.addr = addr; creq.size = size; creq.len = len;
      end else begin
        creq.addr = $urandom; creq.size = 3'($urandom); creq.len = 4'($urandom);
      end
      if (axi_req.arvalid) begin
        axi_resp.arready = (addr_cycles >= ar_delay);
        cap_addr({axi_req.arid, axi_req.araddr, axi_req.arlen, axi_req.arsize, axi_req.arburst}, cyc);
      end
      if (axi_req.rready && beat <= last_at) begin
        if (gap_after >= 0 && beat == gap_after + 1 && !gap_done) begin
          gap_done = 1'b1;
        end else begin
          axi_resp.rvalid = 1'b1;
          axi_resp.rdata  = exp_q[beat];
          axi_resp.rlast  = (beat == last_at);
          axi_resp.rresp  = 2'($urandom);
        end
      end
      if (rst_at >= 0 && beat == rst_at && axi_resp.rvalid) reset = 1'b1;
      #1;
      if (cresp.ready) begin
        pulse_cnt++;
        obs_data.push_back(cresp.data);
        obs_last.push_back(cresp.last);
        if (!axi_resp.rvalid) stray++;
      end else if (cresp.last) begin
        stray++;
      end
      if (axi_resp.rvalid) begin
        if (axi_resp.rlast || reset) done = 1'b1;
        beat++;
      end
    end
    if (!done) timeout++;
    if (reset) begin
      @(negedge clk);
      reset = 1'b0; creq = '0; axi_resp = '0;
      #1;
      post_v = {axi_req.arvalid, axi_req.awvalid, axi_req.wvalid, axi_req.rready, axi_req.bready};
      post_c = cresp;
    end
  endtask

  // Write: master advances its data on each cresp.ready; wmode 1 toggles wready.
  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] len,
                          input logic [3:0] strobe, input int aw_delay, input int wmode, input int b_delay);
    int m = 0;
    int wl_cyc = -1;
    bit done = 1'b0;
    obs_reset();
    for (int i = 0; i <= int'(len); i++) exp_q.push_back($urandom);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      axi_resp = '0;
      creq.valid = 1'b1; creq.is_write = 1'b1; creq.strobe = strobe; creq.data = exp_q[m];
      if (cyc == 0) begin
        creq.addr = addr; creq.size = size; creq.len = len;
      end else begin
        creq.addr = $urandom; creq.size = 3'($urandom); creq.len = 4'($urandom);
      end
      if (axi_req.awvalid) begin
        axi_resp.awready = (addr_cycles >= aw_delay);
        cap_addr({axi_req.awid, axi_req.awaddr, axi_req.awlen, axi_req.awsize, axi_req.awburst}, cyc);
      end
      if (axi_req.wvalid) axi_resp.wready = (wmode == 0) ? 1'b1 : (cyc % 2 == 1);
      if (axi_req.bready && wl_cyc >= 0 && cyc >= wl_cyc + b_delay) begin
        axi_resp.bvalid = 1'b1;
        axi_resp.bresp  = 2'($urandom);
      end
      #1;
      if (axi_req.wvalid && axi_resp.wready) begin
        obs_wdata.push_back(axi_req.wdata);
        obs_wstrb.push_back(axi_req.wstrb);
        obs_wlast.push_back(axi_req.wlast);
        if (axi_req.wlast && wl_cyc < 0) wl_cyc = cyc;
      end
      if (cresp.ready) begin
        pulse_cnt++;
        if (cresp.last) begin
          last_cnt++;
          if (axi_resp.bvalid) last_in_b++;
        end else if (!(axi_req.wvalid && axi_resp.wready)) begin
          stray++;
        end else if (m < int'(len)) begin
          m++;
        end
      end else if (cresp.last) begin
        stray++;
      end
      if (axi_resp.bvalid) done = 1'b1;
    end
    if (!done) timeout++;
  endtask

  task automatic test_reset();
    reset = 1'b1; axi_resp = '0; creq = '0;
    creq.valid = 1'b1; creq.addr = $urandom;
    repeat (3) @(negedge clk);
    reset = 1'b0; creq = '0;
    #1;
    checks++;
    if ({axi_req.arvalid, axi_req.awvalid, axi_req.wvalid, axi_req.rready, axi_req.bready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_valids: got %b expected 00000",
               {axi_req.arvalid, axi_req.awvalid, axi_req.wvalid, axi_req.rready, axi_req.bready});
    end
    checks++;
    if (cresp !== '0) begin
      failures++; $display("FAIL reset_cresp: got %h expected 0", cresp);
    end
  endtask

  task automatic test_single_read();
    do_read(32'h1FC0_0000, 3'd2, 4'd0, 3, -1, 0, -1);
    checks++;
    if (a_fields !== {TB_ID, 32'h1FC0_0000, 8'd0, 3'd2, AXI_BURST_INCR}) begin
      failures++; $display("FAIL sread_ar_fields: got %h expected %h", a_fields,
                           {TB_ID, 32'h1FC0_0000, 8'd0, 3'd2, AXI_BURST_INCR});
    end
    checks++;
    if (addr_cycles !== 4 || !a_stable) begin
      failures++; $display("FAIL sread_ar_hold: got cycles=%0d stable=%0d expected 4/1", addr_cycles, a_stable);
    end
    checks++;
    if (addr_rise !== 1) begin
      failures++; $display("FAIL sread_latency: got %0d expected 1", addr_rise);
    end
    checks++;
    if (read_data_errs() !== 0 || stray !== 0 || timeout !== 0) begin
      failures++; $display("FAIL sread_data: got errs=%0d stray=%0d timeout=%0d expected 0/0/0",
                           read_data_errs(), stray, timeout);
    end
  endtask

  task automatic test_burst_read();
    idle(1);
    do_read(32'h0000_1000, 3'd2, 4'd3, 0, 1, 3, -1);
    checks++;
    if (pulse_cnt !== 4) begin
      failures++; $display("FAIL bread_pulses: got %0d expected 4", pulse_cnt);
    end
    checks++;
    if (a_fields !== {TB_ID, 32'h0000_1000, 8'd3, 3'd2, AXI_BURST_INCR}) begin
      failures++; $display("FAIL bread_ar_fields: got %h expected %h", a_fields,
                           {TB_ID, 32'h0000_1000, 8'd3, 3'd2, AXI_BURST_INCR});
    end
    checks++;
    if (read_data_errs() !== 0 || stray !== 0 || timeout !== 0) begin
      failures++; $display("FAIL bread_data: got errs=%0d stray=%0d timeout=%0d expected 0/0/0",
                           read_data_errs(), stray, timeout);
    end
  endtask

  task automatic test_single_write();
    idle(2);
    do_write(32'hBFAF_8000, 3'd2, 4'd0, 4'b0011, 1, 0, 5);
    exp_q[0] = 32'h1234_5678;
    checks++;
    if (a_fields !== {TB_ID, 32'hBFAF_8000, 8'd0, 3'd2, AXI_BURST_INCR} || !a_stable) begin
      failures++; $display("FAIL swrite_aw_fields: got %h stable=%0d expected %h", a_fields, a_stable,
                           {TB_ID, 32'hBFAF_8000, 8'd0, 3'd2, AXI_BURST_INCR});
    end
    checks++;
    if (obs_wdata.size() !== 1 || obs_wstrb[0] !== 4'b0011 || obs_wlast[0] !== 1'b1) begin
      failures++; $display("FAIL swrite_wbeat: got beats=%0d expected 1 with strb 0011 and wlast", obs_wdata.size());
    end
    checks++;
    if (pulse_cnt !== 1 || last_cnt !== 1 || last_in_b !== 1 || stray !== 0 || timeout !== 0) begin
      failures++; $display("FAIL swrite_cresp: got pulses=%0d last=%0d in_b=%0d stray=%0d timeout=%0d expected 1/1/1/0/0",
                           pulse_cnt, last_cnt, last_in_b, stray, timeout);
    end
  endtask

  task automatic test_burst_write();
    idle(1);
    do_write(32'h8000_0040, 3'd2, 4'd15, 4'b1111, 2, 1, 2);
    checks++;
    if (write_beat_errs(4'b1111) !== 0) begin
      failures++; $display("FAIL bwrite_beats: got errs=%0d beats=%0d expected 0 errs/16 beats",
                           write_beat_errs(4'b1111), obs_wdata.size());
    end
    checks++;
    if (pulse_cnt !== 16 || last_cnt !== 1 || last_in_b !== 1 || stray !== 0 || timeout !== 0) begin
      failures++; $display("FAIL bwrite_cresp: got pulses=%0d last=%0d in_b=%0d stray=%0d timeout=%0d expected 16/1/1/0/0",
                           pulse_cnt, last_cnt, last_in_b, stray, timeout);
    end
    checks++;
    if (ovl_cnt !== 0) begin
      failures++; $display("FAIL bwrite_overlap: got %0d expected 0", ovl_cnt);
    end
  endtask

  task automatic test_reset_mid();
    idle(1);
    do_read(32'h0000_2000, 3'd2, 4'd3, 0, -1, 3, 1);
    checks++;
    if (post_v !== 5'b0 || post_c !== '0) begin
      failures++; $display("FAIL midrst_outputs: got valids=%b cresp=%h expected 0/0", post_v, post_c);
    end
    do_read(32'h0000_3000, 3'd1, 4'd2, 1, -1, 2, -1);
    checks++;
    if (addr_rise !== 1 || read_data_errs() !== 0 || timeout !== 0) begin
      failures++; $display("FAIL midrst_recover: got rise=%0d errs=%0d timeout=%0d expected 1/0/0",
                           addr_rise, read_data_errs(), timeout);
    end
  endtask

  task automatic test_back_to_back();
    idle(1);
    do_write(32'h1000_0000, 3'd2, 4'd0, 4'b1000, 0, 0, 1);
    checks++;
    if (last_in_b !== 1 || write_beat_errs(4'b1000) !== 0) begin
      failures++; $display("FAIL b2b_write: got in_b=%0d errs=%0d expected 1/0", last_in_b, write_beat_errs(4'b1000));
    end
    do_read(32'h1000_0004, 3'd2, 4'd0, 0, -1, 0, -1);
    checks++;
    if (addr_rise !== 1 || read_data_errs() !== 0) begin
      failures++; $display("FAIL b2b_read: got rise=%0d errs=%0d expected 1/0", addr_rise, read_data_errs());
    end
    checks++;
    if (ovl_cnt !== 0) begin
      failures++; $display("FAIL b2b_overlap: got %0d expected 0", ovl_cnt);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  len, strobe;
      int          last_at;
      addr = $urandom; size = 3'($urandom_range(2, 0)); len = 4'($urandom);
      strobe = 4'($urandom);
      idle(int'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) begin
        do_write(addr, size, len, strobe, int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
                 int'($urandom_range(4, 1)));
        checks++;
        if (write_beat_errs(strobe) !== 0 || pulse_cnt !== int'(len) + 1 || last_in_b !== 1 ||
            stray !== 0 || timeout !== 0) begin
          failures++; $display("FAIL rand_write[%0d]: got errs=%0d pulses=%0d in_b=%0d stray=%0d timeout=%0d expected 0/%0d/1/0/0",
                               t, write_beat_errs(strobe), pulse_cnt, last_in_b, stray, timeout, int'(len) + 1);
        end
      end else begin
        last_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(int'(len), 0)) : int'(len);
        do_read(addr, size, len, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)) - 1, last_at, -1);
        checks++;
        if (read_data_errs() !== 0 || stray !== 0 || timeout !== 0) begin
          failures++; $display("FAIL rand_read[%0d]: got errs=%0d stray=%0d timeout=%0d expected 0/0/0",
                               t, read_data_errs(), stray, timeout);
        end
      end
      checks++;
      if (a_fields !== {TB_ID, addr, to_axi_len(len), size, AXI_BURST_INCR} || !a_stable || addr_rise !== 1) begin
        failures++; $display("FAIL rand_addr[%0d]: got %h stable=%0d rise=%0d expected %h/1/1", t, a_fields, a_stable,
                             addr_rise, {TB_ID, addr, to_axi_len(len), size, AXI_BURST_INCR});
      end
    end
    checks++;
    if (ovl_cnt !== 0) begin
      failures++; $display("FAIL rand_overlap: got %0d expected 0", ovl_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; creq = '0; axi_resp = '0;
    test_reset();
    test_single_read();
    test_burst_read();
    test_single_write();
    test_burst_write();
    test_reset_mid();
    test_back_to_back();
    test_random();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
